// File: rtl/game_input_ctrl_if.sv
// Game-control bundle between the AHB register block and the paddle logic.
// Carries debounced-input sources in and paddle/state results out.
interface game_input_ctrl_if;
    logic [1:0] mcu_btn;
    logic [1:0] mcu_sw;
    logic       mcu_str;
    logic       mcu_img;
    logic       frame_tick;
    logic [9:0] paddle_x;
    logic [7:0] paddle_len;
    logic       game_run;
    logic       show_game;
    logic       upd;

    modport master (
        output mcu_btn, mcu_sw, mcu_str, mcu_img, frame_tick,
        input  paddle_x, paddle_len, game_run, show_game, upd
    );

    modport slave (
        input  mcu_btn, mcu_sw, mcu_str, mcu_img, frame_tick,
        output paddle_x, paddle_len, game_run, show_game, upd
    );
endinterface

// File: rtl/game_input_ctrl.sv
// Synchronises and debounces game-control bits, runs the MENU/PAUSE/RUN
// state machine and moves a clamped paddle once per frame.
module game_input_ctrl #(
    parameter int DB_CYCLES = 50000,
    parameter int SCREEN_W  = 640,
    parameter int STEP      = 4
) (
    input logic              AHB_HCLK,
    input logic              AHB_HRESETn,
    game_input_ctrl_if.slave bus
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] DB_MAX = CW'(DB_CYCLES - 1);
    localparam logic [9:0] X_RST = 10'((SCREEN_W - 32) / 2);

    typedef enum logic [1:0] {MENU, PAUSE, RUN} state_t;

    logic [5:0] raw, sync1, sync2, stb;
    logic       str_prev, str_rise;
    state_t     state_q, state_d;
    logic [9:0] x_q, x_d, x_tick;
    logic [7:0] len_q, len_d, len_new;
    logic       upd_q, run_q, show_q;
    logic       menu_entry, go_left, go_right;
    logic signed [10:0] cand, lim;
    logic [10:0] ctr;

    // bits: [1:0] btn, [3:2] sw, [4] str, [5] img
    assign raw = {bus.mcu_img, bus.mcu_str, bus.mcu_sw, bus.mcu_btn};

    always_ff @(posedge AHB_HCLK or negedge AHB_HRESETn) begin
        if (!AHB_HRESETn) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < 6; i++) begin : g_db
        logic [CW-1:0] cnt;
        logic          bit_q;
        always_ff @(posedge AHB_HCLK or negedge AHB_HRESETn) begin
            if (!AHB_HRESETn) begin
                cnt   <= '0;
                bit_q <= 1'b0;
            end else if (sync2[i] == bit_q) begin
                cnt <= '0;
            end else if (cnt == DB_MAX) begin
                cnt   <= '0;
                bit_q <= sync2[i];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
        assign stb[i] = bit_q;
    end

    assign str_rise = stb[4] & ~str_prev;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MENU:    if (stb[5]) state_d = PAUSE;
            PAUSE:   if (!stb[5]) state_d = MENU;
                     else if (str_rise) state_d = RUN;
            RUN:     if (!stb[5]) state_d = MENU;
                     else if (str_rise) state_d = PAUSE;
            default: state_d = MENU;
        endcase
    end

    always_comb begin
        len_new = 8'd32;
        unique case (stb[3:2])
            2'b00: len_new = 8'd32;
            2'b01: len_new = 8'd64;
            2'b10: len_new = 8'd96;
            2'b11: len_new = 8'd128;
            default: len_new = 8'd32;
        endcase
    end

    assign go_left  = (state_q == RUN) & stb[0] & ~stb[1];
    assign go_right = (state_q == RUN) & stb[1] & ~stb[0];

    always_comb begin
        cand = $signed({1'b0, x_q});
        unique case (1'b1)
            go_left:  cand = $signed({1'b0, x_q}) - $signed(11'(STEP));
            go_right: cand = $signed({1'b0, x_q}) + $signed(11'(STEP));
            default:  cand = $signed({1'b0, x_q});
        endcase
        lim = $signed(11'(SCREEN_W) - {3'b000, len_new});
        if (cand < 0)
            x_tick = '0;
        else if (cand > lim)
            x_tick = lim[9:0];
        else
            x_tick = cand[9:0];
    end

    assign menu_entry = (state_q != MENU) && (state_d == MENU);
    assign ctr = (11'(SCREEN_W) - {3'b000, len_q}) >> 1;

    always_comb begin
        x_d   = x_q;
        len_d = len_q;
        if (bus.frame_tick) begin
            x_d   = x_tick;
            len_d = len_new;
        end
        // recentring uses the length in force before this cycle
        if (menu_entry)
            x_d = ctr[9:0];
    end

    always_ff @(posedge AHB_HCLK or negedge AHB_HRESETn) begin
        if (!AHB_HRESETn) begin
            state_q  <= MENU;
            x_q      <= X_RST;
            len_q    <= 8'd32;
            upd_q    <= 1'b0;
            run_q    <= 1'b0;
            show_q   <= 1'b0;
            str_prev <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            len_q    <= len_d;
            upd_q    <= (x_d != x_q) || (len_d != len_q);
            run_q    <= (state_d == RUN);
            show_q   <= (state_d != MENU);
            str_prev <= stb[4];
        end
    end

    assign bus.paddle_x   = x_q;
    assign bus.paddle_len = len_q;
    assign bus.game_run   = run_q;
    assign bus.show_game  = show_q;
    assign bus.upd        = upd_q;

endmodule
